// File: rtl/spi_mem_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one shared SPI transaction engine.
// Define ARB_STARVE_GUARD_EN to bound data priority with the instruction-starvation counter.
module spi_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_flag,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        spi_start,
    output logic        spi_sel,
    output logic        spi_we,
    output logic [31:0] spi_addr,
    output logic [31:0] spi_wdata,
    output logic [2:0]  spi_flag,
    input  logic        spi_done,
    input  logic [31:0] spi_rdata,
    output logic        grant_d
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_t      state_q, state_d;
    logic        spi_start_q, spi_start_d;
    logic        spi_sel_q, spi_sel_d;
    logic        spi_we_q, spi_we_d;
    logic [31:0] spi_addr_q, spi_addr_d;
    logic [31:0] spi_wdata_q, spi_wdata_d;
    logic [2:0]  spi_flag_q, spi_flag_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_ready_q, i_ready_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_ready_q, d_ready_d;
    logic        grant_d_q, grant_d_d;

    logic        forced_instr;
    logic        take_data;
    logic        take_instr;

    assign take_data  = (state_q == IDLE) && d_req && !forced_instr;
    assign take_instr = (state_q == IDLE) && !take_data && i_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT4 = STARVE_LIMIT[3:0];

    logic [3:0] starve_q, starve_d;

    assign forced_instr = (starve_q >= LIMIT4) && i_req;

    // Counts data grants that jumped ahead of a waiting fetch; only IDLE cycles matter.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (!i_req || take_instr) begin
                starve_d = 4'd0;
            end else if (take_data && starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign forced_instr = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        spi_start_d = 1'b0;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        spi_sel_d   = spi_sel_q;
        spi_we_d    = spi_we_q;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;
        spi_flag_d  = spi_flag_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        grant_d_d   = grant_d_q;

        case (state_q)
            IDLE: begin
                if (take_data) begin
                    grant_d_d   = 1'b1;
                    spi_we_d    = d_we;
                    spi_addr_d  = d_addr;
                    spi_wdata_d = d_wdata;
                    spi_flag_d  = d_flag;
                    spi_sel_d   = ~d_addr[31];
                    spi_start_d = 1'b1;
                    state_d     = ISSUE;
                end else if (take_instr) begin
                    grant_d_d   = 1'b0;
                    spi_we_d    = 1'b0;
                    spi_addr_d  = i_addr;
                    spi_wdata_d = 32'h0;
                    spi_flag_d  = 3'b010;
                    spi_sel_d   = ~i_addr[31];
                    spi_start_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Write completions also refresh d_rdata; the content is meaningless there.
                if (spi_done) begin
                    if (grant_d_q) begin
                        d_rdata_d = spi_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = spi_rdata;
                        i_ready_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            spi_start_q <= 1'b0;
            spi_sel_q   <= 1'b0;
            spi_we_q    <= 1'b0;
            spi_addr_q  <= 32'h0;
            spi_wdata_q <= 32'h0;
            spi_flag_q  <= 3'b000;
            i_rdata_q   <= 32'h0;
            i_ready_q   <= 1'b0;
            d_rdata_q   <= 32'h0;
            d_ready_q   <= 1'b0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            spi_start_q <= spi_start_d;
            spi_sel_q   <= spi_sel_d;
            spi_we_q    <= spi_we_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            spi_flag_q  <= spi_flag_d;
            i_rdata_q   <= i_rdata_d;
            i_ready_q   <= i_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_ready_q   <= d_ready_d;
            grant_d_q   <= grant_d_d;
        end
    end

    assign spi_start = spi_start_q;
    assign spi_sel   = spi_sel_q;
    assign spi_we    = spi_we_q;
    assign spi_addr  = spi_addr_q;
    assign spi_wdata = spi_wdata_q;
    assign spi_flag  = spi_flag_q;
    assign i_rdata   = i_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign grant_d   = grant_d_q;

endmodule
